// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- unsigned repeated-subtraction divider
//
// Purpose:
//   Divides an XLEN-bit unsigned dividend by an XLEN-bit unsigned divisor by
//   repeatedly subtracting the divisor from a running remainder. Each
//   subtraction increments the quotient. A small three-state controller
//   sequences a separate datapath that holds the registers, comparator,
//   subtractor and incrementer.
//
// Parameters:
//   XLEN         operand, quotient and remainder width in bits (default 16)
//
// Ports:
//   clk_i        single clock, rising-edge active
//   reset_i      asynchronous active-high reset
//   ld_input_i   load request, accepted only on an edge where ready_o = 1
//   a_i          unsigned dividend, sampled on the accepting edge
//   b_i          unsigned divisor, sampled on the accepting edge
//   ready_o      high in IDLE: a new operation can be accepted
//   valid_o      one-cycle pulse in DONE: the result is complete
//   quotient_o   unsigned quotient (all ones on divide-by-zero)
//   remainder_o  unsigned remainder (the dividend on divide-by-zero)
//   dbz_o        divide-by-zero flag for the current result
//
// Latency from the accepting edge E0:
//   b != 0 : valid_o is high between E(q+1) and E(q+2)
//   b == 0 : valid_o is high between E0 and E1
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// div_ctrl -- controller
//
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset
//   ld_input_i      load request from the user
//   b_zero          datapath flag: the presented divisor is zero
//   rem_ge          datapath flag: remainder >= divisor
//   load_op         load operands and start a normal division
//   load_zero       load the divide-by-zero result
//   step            perform one subtract / increment step
//   ready           controller is in IDLE
//   valid           controller is in DONE
// -----------------------------------------------------------------------------
module div_ctrl (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ld_input_i,
    input  logic b_zero,
    input  logic rem_ge,
    output logic load_op,
    output logic load_zero,
    output logic step,
    output logic ready,
    output logic valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_op    = 1'b0;
        load_zero  = 1'b0;
        step       = 1'b0;
        ready      = 1'b0;
        valid      = 1'b0;

        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (ld_input_i) begin
                    if (b_zero) begin
                        // Result is known immediately, so CALC is skipped.
                        load_zero  = 1'b1;
                        state_next = DONE;
                    end else begin
                        load_op    = 1'b1;
                        state_next = CALC;
                    end
                end
            end

            CALC: begin
                if (rem_ge) begin
                    step = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end

            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// -----------------------------------------------------------------------------
// div_datapath -- registers, comparator, subtractor and incrementer
//
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset
//   a_i, b_i        operands presented by the user
//   load_op         load rem := a, divisor := b, quot := 0, dbz := 0
//   load_zero       load quot := all ones, rem := a, dbz := 1
//   step            rem := rem - divisor, quot := quot + 1
//   b_zero          presented divisor is zero
//   rem_ge          remainder >= divisor
//   quot, rem, dbz  register contents, driven straight to the outputs
// -----------------------------------------------------------------------------
module div_datapath #(
    parameter int XLEN = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            load_op,
    input  logic            load_zero,
    input  logic            step,
    output logic            b_zero,
    output logic            rem_ge,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            dbz
);

    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN-1:0] divisor_next;
    logic            dbz_reg;
    logic            dbz_next;

    logic [XLEN-1:0] rem_diff;
    logic [XLEN-1:0] quot_inc;

    // Functional units.
    assign b_zero   = (b_i == '0);
    assign rem_ge   = (rem_reg >= divisor_reg);
    assign rem_diff = rem_reg - divisor_reg;
    assign quot_inc = quot_reg + XLEN'(1);

    always_comb begin
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        divisor_next = divisor_reg;
        dbz_next     = dbz_reg;

        if (load_op) begin
            quot_next    = '0;
            rem_next     = a_i;
            divisor_next = b_i;
            dbz_next     = 1'b0;
        end else if (load_zero) begin
            // The divisor register is left alone; it is not consulted
            // again until the next normal load overwrites it.
            quot_next = '1;
            rem_next  = a_i;
            dbz_next  = 1'b1;
        end else if (step) begin
            // rem >= divisor here, so the quotient is bounded by the
            // dividend and the incrementer cannot wrap.
            quot_next = quot_inc;
            rem_next  = rem_diff;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            divisor_reg <= divisor_next;
            dbz_reg     <= dbz_next;
        end
    end

    assign quot = quot_reg;
    assign rem  = rem_reg;
    assign dbz  = dbz_reg;

endmodule

// -----------------------------------------------------------------------------
// div -- top level: controller plus datapath
// -----------------------------------------------------------------------------
module div #(
    parameter int XLEN = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ld_input_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            dbz_o
);

    logic load_op;
    logic load_zero;
    logic step;
    logic b_zero;
    logic rem_ge;

    div_ctrl u_ctrl (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ld_input_i (ld_input_i),
        .b_zero     (b_zero),
        .rem_ge     (rem_ge),
        .load_op    (load_op),
        .load_zero  (load_zero),
        .step       (step),
        .ready      (ready_o),
        .valid      (valid_o)
    );

    div_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .load_op   (load_op),
        .load_zero (load_zero),
        .step      (step),
        .b_zero    (b_zero),
        .rem_ge    (rem_ge),
        .quot      (quotient_o),
        .rem       (remainder_o),
        .dbz       (dbz_o)
    );

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- directed self-checking bench for the repeated-subtraction divider
//
// Inputs change on the falling edge or 1 time unit after a rising edge;
// outputs are sampled 1 time unit after a rising edge. Edge counts are
// taken relative to the accepting edge E0.
// -----------------------------------------------------------------------------
module tb_div;

    localparam int XLEN = 16;

    logic            clk;
    logic            reset;
    logic            ld_input;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ready;
    logic            valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            dbz;

    int checks;
    int failures;

    div #(
        .XLEN (XLEN)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .ld_input_i  (ld_input),
        .a_i         (a),
        .b_i         (b),
        .ready_o     (ready),
        .valid_o     (valid),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .dbz_o       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic single operation: accept at E0, count edges until valid_o,
    // check result, then check the return to IDLE with the result held.
    task automatic run_op(input string name,
                          input logic [XLEN-1:0] op_a,
                          input logic [XLEN-1:0] op_b,
                          input logic [XLEN-1:0] exp_q,
                          input logic [XLEN-1:0] exp_r,
                          input logic            exp_dbz,
                          input int              exp_lat);
        int n;
        @(negedge clk);
        a        = op_a;
        b        = op_b;
        ld_input = 1'b1;
        @(posedge clk);          // E0
        #1;
        ld_input = 1'b0;
        n = 0;
        while (!valid && n < exp_lat + 10) begin
            @(posedge clk);
            n++;
            #1;
        end
        checks++;
        if (n !== exp_lat || valid !== 1'b1) begin
            failures++;
            $display("FAIL %s latency: got %0d edges (valid=%b), expected %0d", name, n, valid, exp_lat);
        end
        checks++;
        if (quotient !== exp_q) begin
            failures++;
            $display("FAIL %s quotient: got %h, expected %h", name, quotient, exp_q);
        end
        checks++;
        if (remainder !== exp_r) begin
            failures++;
            $display("FAIL %s remainder: got %h, expected %h", name, remainder, exp_r);
        end
        checks++;
        if (dbz !== exp_dbz) begin
            failures++;
            $display("FAIL %s dbz: got %b, expected %b", name, dbz, exp_dbz);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_during_valid: got %b, expected 0", name, ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL %s after_done: got valid=%b ready=%b, expected valid=0 ready=1", name, valid, ready);
        end
        checks++;
        if (quotient !== exp_q || remainder !== exp_r || dbz !== exp_dbz) begin
            failures++;
            $display("FAIL %s hold_in_idle: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                     name, quotient, remainder, dbz, exp_q, exp_r, exp_dbz);
        end
        $display("op %s: a=%0d b=%0d -> q=%0d r=%0d dbz=%b after %0d edges", name, op_a, op_b,
                 quotient, remainder, dbz, n);
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || quotient !== '0 || remainder !== '0 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL %s: got ready=%b valid=%b q=%h r=%h dbz=%b, expected ready=1 valid=0 q=0 r=0 dbz=0",
                     name, ready, valid, quotient, remainder, dbz);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ld_input = 1'b1;     // must be ignored during reset
        a        = 16'd9;
        b        = 16'd3;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset_held");
        @(negedge clk);
        ld_input = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("after_reset");
        $display("reset: ready=%b valid=%b q=%h r=%h dbz=%b", ready, valid, quotient, remainder, dbz);
    endtask

    task automatic test_basic();
        run_op("a100_b7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 15);
        run_op("a5_b9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1);
        run_op("a0_b5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1);
        run_op("a21_b21", 16'd21, 16'd21, 16'd1, 16'd0, 1'b0, 2);
    endtask

    task automatic test_dbz();
        run_op("dbz", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0);
        // A normal operation afterwards must clear the flag.
        run_op("after_dbz", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 3);
    endtask

    task automatic test_max();
        run_op("max", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 65536);
    endtask

    // Load held high: first op 20/5 (q=4) accepted at E0, valid after E5,
    // IDLE after E6, second op 21/4 (q=5, r=1) accepted at E7, valid after E13.
    task automatic test_back_to_back();
        logic exp_valid;
        @(negedge clk);
        a        = 16'd20;
        b        = 16'd5;
        ld_input = 1'b1;
        @(posedge clk);          // E0
        #1;
        a = 16'd21;              // a restart during CALC would use these
        b = 16'd4;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk);
            #1;
            exp_valid = (n == 5) || (n == 13);
            checks++;
            if (valid !== exp_valid) begin
                failures++;
                $display("FAIL held_load valid@E%0d: got %b, expected %b", n, valid, exp_valid);
            end
            if (n == 5) begin
                checks++;
                if (quotient !== 16'd4 || remainder !== 16'd0) begin
                    failures++;
                    $display("FAIL held_load first_result: got q=%0d r=%0d, expected q=4 r=0", quotient, remainder);
                end
            end
            if (n == 6) begin
                checks++;
                if (ready !== 1'b1) begin
                    failures++;
                    $display("FAIL held_load ready@E6: got %b, expected 1", ready);
                end
            end
            if (n == 7) begin
                ld_input = 1'b0;
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL held_load accept@E7: got ready=%b, expected 0", ready);
                end
            end
            if (n == 13) begin
                checks++;
                if (quotient !== 16'd5 || remainder !== 16'd1) begin
                    failures++;
                    $display("FAIL held_load second_result: got q=%0d r=%0d, expected q=5 r=1", quotient, remainder);
                end
            end
        end
        @(posedge clk);
        #1;
        $display("back_to_back: second result q=%0d r=%0d ready=%b", quotient, remainder, ready);
    endtask

    task automatic test_reset_mid_calc();
        bit seen_valid;
        @(negedge clk);
        a        = 16'd1000;
        b        = 16'd3;
        ld_input = 1'b1;
        @(posedge clk);          // E0
        #1;
        ld_input = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (quotient !== 16'd10 || remainder !== 16'd970) begin
            failures++;
            $display("FAIL abort progress@E10: got q=%0d r=%0d, expected q=10 r=970", quotient, remainder);
        end
        #1;
        reset = 1'b1;            // no clock edge between here and the check
        #1;
        check_idle_zero("abort_async");
        ld_input = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("abort_held");
        @(negedge clk);
        reset    = 1'b0;
        ld_input = 1'b0;
        seen_valid = 1'b0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort no_valid: got valid pulse=%b, expected 0", seen_valid);
        end
        check_idle_zero("abort_idle");
        $display("reset_mid_calc: aborted, ready=%b valid_seen=%b", ready, seen_valid);
        run_op("restart", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 334);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ld_input = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_basic();
        test_dbz();
        test_back_to_back();
        test_reset_mid_calc();
        test_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The module SHALL have parameter XLEN, default 16, which sets the operand, quotient and remainder width in bits.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port ld_input_i, input, 1 bit: load request; it is accepted only on a rising edge where ready_o=1.
REQ-005 The module SHALL have port a_i, input, XLEN bits: unsigned dividend, sampled on the accepting edge.
REQ-006 The module SHALL have port b_i, input, XLEN bits: unsigned divisor, sampled on the accepting edge.
REQ-007 The module SHALL have port ready_o, output, 1 bit: high only in IDLE, meaning a new operation can be accepted.
REQ-008 The module SHALL have port valid_o, output, 1 bit: high for exactly one cycle, in DONE, meaning the result is complete.
REQ-009 The module SHALL have port quotient_o, output, XLEN bits: unsigned quotient.
REQ-010 The module SHALL have port remainder_o, output, XLEN bits: unsigned remainder.
REQ-011 The module SHALL have port dbz_o, output, 1 bit: divide-by-zero flag for the current result.

Function
REQ-012 The divider SHALL be implemented by repeated subtraction, with separate control (FSM) and datapath (registers, comparator, subtractor, incrementer).
REQ-013 The FSM SHALL have three states, encoded in 2 bits: IDLE, CALC and DONE.
REQ-014 In IDLE, when ld_input_i=1 and b_i!=0, the edge SHALL set rem:=a_i, div:=b_i, quot:=0 and dbz:=0, and move to CALC.
REQ-015 In IDLE, when ld_input_i=1 and b_i=0, the edge SHALL set quot:=all ones, rem:=a_i and dbz:=1, and move directly to DONE, skipping CALC.
REQ-016 In IDLE, when ld_input_i=0, all registers SHALL hold their values.
REQ-017 In CALC, when rem>=div, each edge SHALL set rem:=rem-div and quot:=quot+1, and stay in CALC.
REQ-018 In CALC, when rem<div, the edge SHALL move to DONE with no register change.
REQ-019 From DONE, the next edge SHALL always move to IDLE.
REQ-020 Latency for b!=0 SHALL be q+1 cycles: if the load is accepted at edge E0, valid_o is high between edges E(q+1) and E(q+2), where q is the final quotient.
REQ-021 Latency for b=0 SHALL be 1 cycle: valid_o is high between edges E0 and E1.
REQ-022 When a_i<b_i, the result SHALL be q=0 and r=a_i after exactly one CALC cycle.
REQ-023 When a_i=0 and b_i!=0, the result SHALL be q=0 and r=0 after one CALC cycle.
REQ-024 ld_input_i SHALL be ignored while in CALC or DONE; a request held high through DONE is accepted on the first edge in IDLE.
REQ-025 quotient_o, remainder_o and dbz_o SHALL be driven directly from the quot, rem and dbz registers.
REQ-026 quotient_o, remainder_o and dbz_o are guaranteed correct only while valid_o=1, and SHALL hold their final values through IDLE until the next accepted load.
REQ-027 The remainder SHALL always satisfy r<b when b!=0, and a = q*b + r exactly.
REQ-028 No overflow SHALL occur: q never exceeds 2^XLEN-1.
REQ-029 Worst-case latency SHALL be 2^XLEN cycles (a=all ones, b=1).
REQ-030 valid_o and ready_o SHALL never be high in the same cycle.

Reset
REQ-031 While reset_i=1, regardless of clk_i, the state SHALL be IDLE and quot, rem, div and dbz SHALL be 0.
REQ-032 During and after reset, outputs SHALL be ready_o=1, valid_o=0, quotient_o=0, remainder_o=0 and dbz_o=0.
REQ-033 ld_input_i SHALL be ignored while reset_i=1.
REQ-034 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately with no valid_o pulse.
REQ-035 After reset is released, the first edge with ld_input_i=1 SHALL start a new operation normally.

Verification
REQ-036 The bench SHALL cover: a=100, b=7, load at E0 -> valid_o high after E15 for one cycle, q=14, r=2, dbz=0.
REQ-037 The bench SHALL cover: a=5, b=9 -> valid_o after E1, q=0, r=5.
REQ-038 The bench SHALL cover: a=0x1234, b=0 -> valid_o after E0, q=0xFFFF, r=0x1234, dbz=1, with ready_o low during that valid cycle.
REQ-039 The bench SHALL cover: a=0xFFFF, b=1 -> valid_o after E65536, q=0xFFFF, r=0.
REQ-040 The bench SHALL cover: ld_input_i held high through a whole operation (a=20, b=5) -> no restart during CALC or DONE, and a second operation is accepted on the first IDLE edge after valid_o.
REQ-041 The bench SHALL cover: reset_i pulsed during CALC of a=1000, b=3 -> state returns to IDLE asynchronously, outputs are zero, ready_o=1, and no valid_o pulse occurs.
